// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed streaming FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int unsigned STAGE_DEPTH = 2;
  localparam int unsigned STAGE_CNT_W = 2;

  // Words held or about to land in the output stage once this cycle's pop retires.
  function automatic logic [2:0] stage_occupancy(
    input logic [STAGE_CNT_W-1:0] cnt,
    input logic                   inflight,
    input logic                   pop
  );
    return 3'(cnt) + 3'(inflight) - 3'(pop);
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM with a registered read port; contents are never reset.
module dual_port_ram #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SIZE_LOG2 = 10
) (
  input  logic                 wclock,
  input  logic                 wenable,
  input  logic [SIZE_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rclock,
  input  logic                 renable,
  input  logic [SIZE_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int unsigned DEPTH = 32'd1 << SIZE_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge wclock) begin
    if (wenable) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge rclock) begin
    if (renable) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_read_stage.sv
// Two-entry output stage (head + skid) that turns RAM read returns into a valid/ready stream.
module fifo_read_stage
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cap_valid,
  input  logic [WIDTH-1:0]       cap_data,
  input  logic                   oready,
  output logic                   ovalid,
  output logic [WIDTH-1:0]       odata,
  output logic [STAGE_CNT_W-1:0] count,
  output logic                   pop_c
);

  logic [WIDTH-1:0]       head_q, head_d;
  logic [WIDTH-1:0]       skid_q, skid_d;
  logic [STAGE_CNT_W-1:0] count_q, count_d;
  logic                   valid_q, valid_d;

  assign pop_c = valid_q && oready;

  // Head always presents the oldest word; skid refills head on pop.
  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q - STAGE_CNT_W'(pop_c) + STAGE_CNT_W'(cap_valid);
    if (pop_c) begin
      if (count_q == STAGE_CNT_W'(STAGE_DEPTH)) begin
        head_d = skid_q;
        if (cap_valid) skid_d = cap_data;
      end else if (cap_valid) begin
        head_d = cap_data;
      end
    end else if (cap_valid) begin
      if (count_q == '0) head_d = cap_data;
      else               skid_d = cap_data;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign ovalid = valid_q;
  assign odata  = head_q;
  assign count  = count_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around a registered dual-port RAM with a two-entry output stage.
// Optional RAM_FIFO_CTRL_BYPASS_EN: pushes into an idle, empty FIFO skip the RAM.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SIZE_LOG2    = 10,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     idata,
  input  logic                 ienable,
  output logic                 iafull,
  output logic                 ifull,
  output logic                 overflow,
  input  logic                 clear_overflow,
  output logic [SIZE_LOG2:0]   level,
  output logic [WIDTH-1:0]     odata,
  output logic                 ovalid,
  input  logic                 oready
);

  localparam int unsigned DEPTH = 32'd1 << SIZE_LOG2;
  localparam int unsigned PTR_W = SIZE_LOG2 + 1;

  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [PTR_W-1:0]       level_q, level_d;
  logic                   ifull_q, ifull_d;
  logic                   iafull_q, iafull_d;
  logic                   overflow_q, overflow_d;
  logic                   inflight_q, inflight_d;

  logic                   push_c, drop_c, wr_c, issue_c, bypass_c;
  logic                   cap_valid_c;
  logic [WIDTH-1:0]       cap_data_c;
  logic [2:0]             occ_c;
  logic [WIDTH-1:0]       ram_rdata;
  logic [STAGE_CNT_W-1:0] stage_count;
  logic                   stage_pop_c;

  always_comb begin
    push_c = ienable && !ifull_q;
    drop_c = ienable && ifull_q;
    occ_c  = stage_occupancy(stage_count, inflight_q, stage_pop_c);
    // Only issue a read if its return is guaranteed a slot in the stage.
    issue_c = (level_q != '0) && (occ_c < 3'(STAGE_DEPTH));
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    bypass_c = push_c && (level_q == '0) && !inflight_q && (occ_c < 3'(STAGE_DEPTH));
`else
    bypass_c = 1'b0;
`endif
    wr_c = push_c && !bypass_c;

    wptr_d     = wptr_q + PTR_W'(wr_c);
    rptr_d     = rptr_q + PTR_W'(issue_c);
    level_d    = wptr_d - rptr_d;
    ifull_d    = (level_d == PTR_W'(DEPTH));
    iafull_d   = ((PTR_W'(DEPTH) - level_d) <= PTR_W'(AFULL_MARGIN));
    inflight_d = issue_c;

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop_c)         overflow_d = 1'b1;

    cap_valid_c = inflight_q || bypass_c;
    cap_data_c  = bypass_c ? idata : ram_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ifull_q    <= 1'b0;
      iafull_q   <= 1'b0;
      overflow_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ifull_q    <= ifull_d;
      iafull_q   <= iafull_d;
      overflow_q <= overflow_d;
      inflight_q <= inflight_d;
    end
  end

  dual_port_ram #(
    .WIDTH     (WIDTH),
    .SIZE_LOG2 (SIZE_LOG2)
  ) u_ram (
    .wclock  (clock),
    .wenable (wr_c),
    .waddr   (wptr_q[SIZE_LOG2-1:0]),
    .wdata   (idata),
    .rclock  (clock),
    .renable (issue_c),
    .raddr   (rptr_q[SIZE_LOG2-1:0]),
    .rdata   (ram_rdata)
  );

  fifo_read_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .clock     (clock),
    .reset     (reset),
    .cap_valid (cap_valid_c),
    .cap_data  (cap_data_c),
    .oready    (oready),
    .ovalid    (ovalid),
    .odata     (odata),
    .count     (stage_count),
    .pop_c     (stage_pop_c)
  );

  assign level    = level_q;
  assign ifull    = ifull_q;
  assign iafull   = iafull_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (D=16, margin 4): vector table plus multi-cycle sequences.
module tb_ram_fifo_ctrl;

`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] idata = '0;
  logic       ienable = 1'b0;
  logic       iafull, ifull, overflow;
  logic       clear_overflow = 1'b0;
  logic [4:0] level;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready = 1'b0;

  ram_fifo_ctrl #(
    .WIDTH        (8),
    .SIZE_LOG2    (4),
    .AFULL_MARGIN (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .idata          (idata),
    .ienable        (ienable),
    .iafull         (iafull),
    .ifull          (ifull),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .level          (level),
    .odata          (odata),
    .ovalid         (ovalid),
    .oready         (oready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Output monitor: order scoreboard and hold-stability under back-pressure.
  logic [7:0] exp_q[$];
  int         pop_cnt = 0;
  int         cyc = 0;
  int         last_pop_cyc = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_data_q = '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      exp_q.delete();
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(ovalid), 32'd1);
        check("hold_data", 32'(odata), 32'(hold_data_q));
      end
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0h expected none", odata);
        end else begin
          check("pop_data", 32'(odata), 32'(exp_q.pop_front()));
        end
        pop_cnt      <= pop_cnt + 1;
        last_pop_cyc <= cyc;
      end
      hold_q      <= ovalid && !oready;
      hold_data_q <= odata;
    end
  end

  task automatic step(input logic rst, input logic ien, input logic [7:0] d,
                      input logic ordy, input logic clr);
    @(negedge clock);
    reset          = rst;
    ienable        = ien;
    idata          = d;
    oready         = ordy;
    clear_overflow = clr;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       ien;
    logic [7:0] din;
    logic       ordy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_ifull;
    logic       e_iafull;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t tv[NV];

  int n, base, first_cyc, exp_lvl;
  bit got_first;

  initial begin
    // Reset, single push latency, then two back-to-back words.
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    if (BYP) begin
      tv[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    end else begin
      tv[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 5'd0, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd0, 1'b0, 1'b0, 1'b0};
    end
    tv[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      if (tv[i].ien && !tv[i].rst) exp_q.push_back(tv[i].din);
      step(tv[i].rst, tv[i].ien, tv[i].din, tv[i].ordy, tv[i].clr);
      check($sformatf("vec%0d_ovalid", i), 32'(ovalid), 32'(tv[i].e_valid));
      if (tv[i].e_valid) check($sformatf("vec%0d_odata", i), 32'(odata), 32'(tv[i].e_data));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].e_level));
      check($sformatf("vec%0d_ifull", i), 32'(ifull), 32'(tv[i].e_ifull));
      check($sformatf("vec%0d_iafull", i), 32'(iafull), 32'(tv[i].e_iafull));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tv[i].e_ovf));
    end

    // Fill with oready low: 18 words fit (16 RAM + 2 stage), 18 and 19 are dropped.
    for (int k = 0; k < 20; k++) begin
      if (k < 18) exp_q.push_back(8'(k));
      step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
      if (k >= 2) exp_lvl = (k - 1 > 16) ? 16 : k - 1;
      else        exp_lvl = BYP ? 0 : 1;
      check($sformatf("fill%0d_level", k), 32'(level), 32'(exp_lvl));
      check($sformatf("fill%0d_iafull", k), 32'(iafull), 32'(exp_lvl >= 12));
      check($sformatf("fill%0d_ifull", k), 32'(ifull), 32'(exp_lvl == 16));
      check($sformatf("fill%0d_overflow", k), 32'(overflow), 32'(k >= 18));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("full_level", 32'(level), 32'd16);
    check("full_head", 32'(odata), 32'h00);
    check("full_ovalid", 32'(ovalid), 32'd1);
    check("full_overflow_sticky", 32'(overflow), 32'd1);

    // Drop and clear in the same cycle: set wins.
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    check("collide_overflow", 32'(overflow), 32'd1);
    check("collide_level", 32'(level), 32'd16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_overflow", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("cleared_stays", 32'(overflow), 32'd0);

    base = pop_cnt;
    for (int c = 0; c < 100 && pop_cnt != base + 18; c++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_count", 32'(pop_cnt - base), 32'd18);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_level", 32'(level), 32'd0);
    check("drain_ovalid", 32'(ovalid), 32'd0);
    check("drain_ifull", 32'(ifull), 32'd0);

    // Random back-pressure over a 100-word burst.
    n = 0;
    base = pop_cnt;
    for (int c = 0; c < 3000 && !(n == 100 && pop_cnt == base + 100); c++) begin
      if (n < 100 && !ifull) begin
        exp_q.push_back(8'(n));
        step(1'b0, 1'b1, 8'(n), 1'($urandom_range(0, 1)), 1'b0);
        n++;
      end else begin
        step(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    check("bp_pushed", 32'(n), 32'd100);
    check("bp_popped", 32'(pop_cnt - base), 32'd100);
    check("bp_overflow", 32'(overflow), 32'd0);

    // Continuous 50-word stream through a 16-deep RAM with oready high.
    base = pop_cnt;
    got_first = 1'b0;
    first_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      exp_q.push_back(8'(8'h40 + i));
      step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      check($sformatf("wrap%0d_level_le1", i), 32'(level <= 5'd1), 32'd1);
      if (!got_first && pop_cnt > base) begin
        got_first = 1'b1;
        first_cyc = last_pop_cyc;
      end
    end
    for (int c = 0; c < 20 && pop_cnt != base + 50; c++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (!got_first && pop_cnt > base) begin
        got_first = 1'b1;
        first_cyc = last_pop_cyc;
      end
    end
    check("wrap_popped", 32'(pop_cnt - base), 32'd50);
    check("wrap_one_per_cycle", 32'(last_pop_cyc - first_cyc), 32'd49);

    // Reset while level=5 and ovalid=1; nothing stale may follow.
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(8'(8'h80 + k));
      step(1'b0, 1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_ovalid", 32'(ovalid), 32'd1);
    check("pre_rst_odata", 32'(odata), 32'h80);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    base = pop_cnt;
    exp_q.push_back(8'h3C);
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    for (int c = 0; c < 10 && pop_cnt != base + 1; c++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_popped", 32'(pop_cnt - base), 32'd1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_no_extra", 32'(pop_cnt - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
